// File: rtl/crc8_frame_checker_if.sv
// ----------------------------------------------------------------------------
// crc8_frame_checker_if
//   Byte-stream and result bundle for the CRC-8 frame checker.
//
//   Handshake: a byte moves on a rising edge where data_valid_i and
//   data_ready_o are both 1 and abort_i is 0. The sender holds data_i and
//   data_last_i stable while data_valid_i=1 and data_ready_o=0.
//   data_ready_o is registered and never depends on data_valid_i in the
//   same cycle.
//
//   Signals (named from the checker's point of view):
//     data_i        8  received byte
//     data_valid_i  1  data_i valid
//     data_last_i   1  data_i is the trailing CRC byte of the frame
//     abort_i       1  synchronous frame abort
//     data_ready_o  1  checker can take a byte this cycle
//     busy_o        1  frame in progress
//     frame_done_o  1  one-cycle result strobe
//     frame_ok_o    1  pass/fail, valid while frame_done_o=1
//     crc_o         8  running CRC register
//     state_o       2  FSM state for debug (0 IDLE, 1 SHIFT, 2 REPORT)
//
//   Modports: master = byte source / result consumer, slave = checker.
// ----------------------------------------------------------------------------
interface crc8_frame_checker_if;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       data_last_i;
  logic       abort_i;
  logic       data_ready_o;
  logic       busy_o;
  logic       frame_done_o;
  logic       frame_ok_o;
  logic [7:0] crc_o;
  logic [1:0] state_o;

  modport master (
    output data_i, data_valid_i, data_last_i, abort_i,
    input  data_ready_o, busy_o, frame_done_o, frame_ok_o, crc_o, state_o
  );

  modport slave (
    input  data_i, data_valid_i, data_last_i, abort_i,
    output data_ready_o, busy_o, frame_done_o, frame_ok_o, crc_o, state_o
  );
endinterface

// File: rtl/crc8_frame_checker.sv
// ----------------------------------------------------------------------------
// crc8_frame_checker
//   Receive-side CRC-8 check. Every byte of a frame, including the trailing
//   CRC byte, is folded into the CRC register one bit per clock, MSB first.
//   After the last byte the checker spends one REPORT cycle showing the
//   residue; a zero residue means the frame is good. No reflection and no
//   final XOR, so a correctly generated frame always leaves residue 0.
//
//   Ports:
//     clk_i    clock, rising edge
//     rst_ni   asynchronous active-low reset
//     bus      crc8_frame_checker_if.slave (byte stream, status, debug state)
//
//   Timing: accept edge E0, shift edges E1..E8, data_ready_o back high after
//   E8 (one byte per 9 cycles). For a last byte, REPORT is the cycle after
//   E8 and the next byte can be taken at E10.
// ----------------------------------------------------------------------------
module crc8_frame_checker #(
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter logic [7:0] INIT       = 8'h00
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  crc8_frame_checker_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] crc_q,   crc_d;
  logic [7:0] sh_q,    sh_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       last_q,  last_d;
  logic       busy_q,  busy_d;
  logic       ready_q, ready_d;
  logic       accept;
  logic       fb;

  // ready_q is only ever 1 while in IDLE, so this is the full accept term.
  assign accept = bus.data_valid_i & ready_q & ~bus.abort_i;

  // Feedback bit of the serial divider: top of CRC against incoming bit.
  assign fb = crc_q[7] ^ sh_q[7];

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    busy_d  = busy_q;

    if (bus.abort_i) begin
      // Abort wins over everything: drop the frame, no result strobe.
      state_d = IDLE;
      crc_d   = INIT;
      cnt_d   = 3'd0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sh_d    = bus.data_i;
            last_d  = bus.data_last_i;
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLYNOMIAL : 8'h00);
          sh_d  = {sh_q[6:0], 1'b0};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = last_q ? REPORT : IDLE;
          end
        end
        REPORT: begin
          // Residue was shown for one cycle; re-arm for the next frame.
          crc_d   = INIT;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          crc_d   = INIT;
          cnt_d   = 3'd0;
          busy_d  = 1'b0;
        end
      endcase
    end

    // Registered ready: high in exactly the cycles spent in IDLE.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      sh_q    <= 8'h00;
      cnt_q   <= 3'd0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Result outputs decode the state register directly, so the strobe also
  // shows during a REPORT cycle in which abort_i is asserted.
  assign bus.data_ready_o = ready_q;
  assign bus.busy_o       = busy_q;
  assign bus.frame_done_o = (state_q == REPORT);
  assign bus.frame_ok_o   = (state_q == REPORT) && (crc_q == 8'h00);
  assign bus.crc_o        = crc_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// ----------------------------------------------------------------------------
// tb_crc8_frame_checker
//   Bench for crc8_frame_checker. Frames are driven through the interface;
//   each frame that must produce a result pushes {ok, residue} into exp_q,
//   and an independent monitor pops on every frame_done_o strobe. The
//   reference residue is textbook polynomial long division of the whole
//   frame (times x^8) by x^8+x^2+x+1.
// ----------------------------------------------------------------------------
module tb_crc8_frame_checker;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  crc8_frame_checker_if bus_if ();

  crc8_frame_checker #(
    .POLYNOMIAL (8'h07),
    .INIT       (8'h00)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [8:0] exp_q[$];   // {expected ok, expected residue}
  logic       after_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Remainder of frame(x) * x^8 modulo the generator, by long division.
  function automatic logic [7:0] model_residue(input logic [7:0] fr[$]);
    bit         bits[$];
    logic [8:0] gen;
    logic [7:0] r;
    int         n;
    gen = 9'h107;
    foreach (fr[i]) begin
      for (int b = 7; b >= 0; b--) bits.push_back(fr[i][b]);
    end
    n = bits.size();
    for (int i = 0; i < 8; i++) bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (bits[i]) begin
        for (int k = 0; k < 9; k++) bits[i+k] = bits[i+k] ^ gen[8-k];
      end
    end
    for (int i = 0; i < 8; i++) r[7-i] = bits[n+i];
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (after_done && rst_n) begin
      check("crc_back_to_init", bus_if.crc_o, 8'h00);
      check("busy_clear_after_report", bus_if.busy_o, 0);
    end
    if (rst_n && bus_if.frame_done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("frame_ok", bus_if.frame_ok_o, e[8]);
        check("residue", bus_if.crc_o, e[7:0]);
        check("busy_in_report", bus_if.busy_o, 1);
      end
    end
    after_done <= rst_n && bus_if.frame_done_o;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send_byte(input logic [7:0] b, input logic last,
                           input int exp_wait, input bit hold);
    int waits = 0;
    bus_if.data_i       = b;
    bus_if.data_last_i  = last;
    bus_if.data_valid_i = 1'b1;
    while (!bus_if.data_ready_o && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check("accept_in_time", (waits < 40) ? 1 : 0, 1);
    if (exp_wait >= 0) check("ready_gap", waits, exp_wait);
    @(negedge clk);
    check("ready_low_after_accept", bus_if.data_ready_o, 0);
    if (!hold) bus_if.data_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input bit expect_strobe,
                            input bit gaps, input int first_wait);
    logic [7:0] r;
    int         g;
    int         ew;
    if (expect_strobe) begin
      r = model_residue(fr);
      exp_q.push_back({(r == 8'h00), r});
    end
    foreach (fr[i]) begin
      if (gaps && i > 0) begin
        g = $urandom_range(0, 3);
        if (g > 0) begin
          bus_if.data_valid_i = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      ew = (i == 0) ? first_wait : (gaps ? -1 : 8);
      send_byte(fr[i], (i == fr.size() - 1), ew, (i != fr.size() - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_crc"},   bus_if.crc_o, 8'h00);
    check({tag, "_ready"}, bus_if.data_ready_o, 0);
    check({tag, "_busy"},  bus_if.busy_o, 0);
    check({tag, "_done"},  bus_if.frame_done_o, 0);
    check({tag, "_ok"},    bus_if.frame_ok_o, 0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_low_before_edge", bus_if.data_ready_o, 0);
    @(posedge clk);
    #1 check("ready_after_first_edge", bus_if.data_ready_o, 1);
    @(negedge clk);
  endtask

  task automatic wait_done(output bit seen);
    int n = 0;
    seen = 0;
    while (!bus_if.frame_done_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    seen = bus_if.frame_done_o;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] good[$];
    logic [7:0] bad[$];
    logic [7:0] fr[$];
    logic [7:0] c;
    bit         seen;
    int         len;

    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    bad  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF5};

    bus_if.data_i       = 8'h00;
    bus_if.data_valid_i = 1'b0;
    bus_if.data_last_i  = 1'b0;
    bus_if.abort_i      = 1'b0;
    rst_n               = 1'b0;
    #1 check_reset_outputs("por");
    release_reset();

    // Good and bad reference frames, valid held high (ready every 9 cycles).
    send_frame(good, 1, 0, 0);
    send_frame(bad,  1, 0, -1);

    // Short frames.
    fr = '{8'h00};         send_frame(fr, 1, 0, -1);
    fr = '{8'h01};         send_frame(fr, 1, 0, -1);
    fr = '{8'h01, 8'h07};  send_frame(fr, 1, 0, -1);

    // Abort during SHIFT of byte 3; the frame must not report.
    repeat (3) @(negedge clk);
    send_byte(8'h31, 1'b0, -1, 1'b1);
    send_byte(8'h32, 1'b0, 8, 1'b1);
    send_byte(8'h33, 1'b0, 8, 1'b0);
    repeat (2) @(negedge clk);
    bus_if.abort_i = 1'b1;
    @(negedge clk);
    bus_if.abort_i = 1'b0;
    check("abort_busy", bus_if.busy_o, 0);
    check("abort_crc", bus_if.crc_o, 8'h00);
    @(negedge clk);
    check("abort_ready", bus_if.data_ready_o, 1);
    send_frame(good, 1, 0, -1);

    // Abort together with valid in IDLE: byte refused, ready stays high.
    repeat (12) @(negedge clk);
    bus_if.data_i       = 8'hA5;
    bus_if.data_last_i  = 1'b1;
    bus_if.data_valid_i = 1'b1;
    bus_if.abort_i      = 1'b1;
    @(negedge clk);
    check("idle_abort_ready", bus_if.data_ready_o, 1);
    check("idle_abort_busy",  bus_if.busy_o, 0);
    bus_if.data_valid_i = 1'b0;
    bus_if.abort_i      = 1'b0;
    @(negedge clk);
    check("idle_abort_state", bus_if.state_o, 0);

    // Async reset mid-SHIFT.
    send_byte(8'h31, 1'b0, -1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("busy_mid_frame", bus_if.busy_o, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_shift");
    release_reset();
    send_frame(good, 1, 0, -1);

    // Async reset during REPORT (strobe itself is still scored).
    fr = '{8'h01};
    send_frame(fr, 1, 0, -1);
    wait_done(seen);
    check("report_reached", seen, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_report");
    release_reset();
    send_frame(good, 1, 0, -1);

    // Back-to-back frames: next accept exactly 10 edges after last accept.
    repeat (12) @(negedge clk);
    send_frame(good, 1, 0, -1);
    fr = '{8'h01, 8'h07};
    send_frame(fr, 1, 0, 9);

    // Random frames, half with a correct CRC, some with idle gaps.
    for (int f = 0; f < 14; f++) begin
      fr.delete();
      len = $urandom_range(0, 5);
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) c = model_residue(fr);
      else c = 8'($urandom_range(0, 255));
      fr.push_back(c);
      send_frame(fr, 1, 1'($urandom_range(0, 1)), -1);
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc8_frame_checker.md
# crc8_frame_checker

Receive-side counterpart of the CRC-8 generator. It consumes a byte stream whose final byte is the transmitted CRC and recomputes CRC-8 bit-serially, MSB first, over every byte, including that trailing CRC byte. At the end of each frame it reports pass/fail: the frame passes when the residue is zero. It sits between the byte deframer and the packet consumer, and exposes its running CRC register for debug and formal checks.

## Interface
- POLYNOMIAL, 8'h07, generator polynomial (implicit x^8 term), non-reflected
- INIT, 8'h00, CRC register value after reset and at the start of each frame
- clk_i  in  1  single clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- data_i  in  8  received byte
- data_valid_i  in  1  data_i valid
- data_last_i  in  1  qualifies data_i as the final (CRC) byte of the frame
- data_ready_o  out  1  checker can accept a byte this cycle
- abort_i  in  1  synchronous frame abort
- busy_o  out  1  frame in progress (at least one byte accepted, result not yet reported)
- frame_done_o  out  1  one-cycle result strobe
- frame_ok_o  out  1  result; meaningful only while frame_done_o=1
- crc_o  out  8  current CRC register

## Operation
- **States:** IDLE, SHIFT, REPORT.
- **Accept:** a byte is accepted on an edge where data_valid_i & data_ready_o & !abort_i.
  - data_i is loaded into an 8-bit shift register.
  - data_last_i is latched.
  - The 3-bit bit counter is cleared.
  - State moves to SHIFT.
  - busy_o is set.
- **SHIFT** (8 edges, one per bit, MSB first), on each edge:
  - fb = crc[7] ^ sh[7]
  - crc <= {crc[6:0],1'b0} ^ (fb ? POLYNOMIAL : 8'h00)
  - sh <= sh << 1
  - counter increments
- **End of SHIFT**, on the edge with counter=7:
  - next state is REPORT if the latched last flag is set, else IDLE.
- **REPORT** (exactly one cycle):
  - frame_done_o=1.
  - frame_ok_o = (crc_o == 8'h00).
  - crc_o holds the residue.
  - On the next edge: crc <= INIT, busy_o <= 0, state IDLE.
- **data_ready_o:** registered; 1 only in IDLE.
- **No final XOR, no reflection.** With matching transmitter settings, a good frame always leaves residue 0.
- **Single-byte frame** (first byte has data_last_i=1): legal; it is checked as a frame of only the CRC byte.
- **abort_i** has the highest priority among synchronous events.
  - On any edge where abort_i=1: state IDLE, crc <= INIT, counter cleared, busy_o <= 0.
  - No frame_done_o is produced, and no byte is accepted on that edge.
  - Abort during REPORT: frame_done_o is still high for that cycle only; the next state is IDLE, as normal.
- data_i and data_last_i are ignored unless a byte is accepted.
- data_valid_i may stay high; holding the byte while data_ready_o=0 is the sender's duty.

## Timing
- **Reset** (rst_ni low, asynchronous):
  - state IDLE, crc_o=INIT, data_ready_o=0, busy_o=0, frame_done_o=0, frame_ok_o=0.
  - data_ready_o rises on the first clock edge after rst_ni deasserts.
- **Reset mid-frame:** all partial state is discarded immediately, with no result strobe.
- **Per byte:** the accept edge E0 is followed by shift edges E1..E8.
  - data_ready_o is 0 from after E0 until after E8.
  - Sustained throughput is one byte per 9 cycles.
- **Last byte:** REPORT is the cycle after E8; frame_done_o is high between E8 and E9.
  - Latency from the last-byte accept edge to frame_done_o rising is 8 edges.
  - The next frame's first byte can be accepted at E10.
- **crc_o** changes only on shift edges, the REPORT exit edge, abort, or reset. It holds stable in IDLE between bytes.

## Test plan
- **Good frame:** frame "123456789" (0x31..0x39) then last byte 0xF4, valid held high.
  - Required: frame_done_o pulses once with frame_ok_o=1 and crc_o=0x00.
  - data_ready_o high one cycle in every 9.
- **Bad frame:** the same frame with last byte 0xF5.
  - Required: frame_ok_o=0, crc_o=0x07 during REPORT, then crc_o returns to 0x00.
- **Short frames:**
  - Single-byte frame 0x00 → frame_ok_o=1.
  - Single-byte frame 0x01 → frame_ok_o=0, crc_o=0x07.
  - Two-byte frame {0x01, last 0x07} → frame_ok_o=1.
- **Abort:** assert abort_i during SHIFT of byte 3 of a good frame, then send the full good frame.
  - Required: no strobe for the aborted frame; the second frame passes.
  - Also assert abort_i together with valid in IDLE: the byte is not accepted and data_ready_o stays 1.
- **Async reset:** drop rst_ni mid-SHIFT and in REPORT.
  - Required: outputs reach their reset values immediately, with no clock.
  - data_ready_o=1 one edge after release.
  - A subsequent good frame passes.
- **Back-to-back frames:** "123456789"+0xF4 immediately followed by {0x01, 0x07}.
  - Required: two strobes, both ok, 10 cycles apart minimum between the last-byte accept and the next accept.
